// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports, the shared memory bus and status/debug
// signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Handshake: mX_req is held high with mX_wr/addr/wdata stable until the
  // single-cycle mX_done pulse; mX_rdata is valid from the done cycle onward.
  logic          m0_req;
  logic          m0_wr;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_done;

  logic          m1_req;
  logic          m1_wr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_done;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic [2:0]    dbg_state;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_rdata, m0_done, m1_rdata, m1_done,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output busy, dbg_state
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_rdata, m0_done, m1_rdata, m1_done,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  busy, dbg_state
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU load/store (port 0)
// and bootloader/DMA (port 1), one access per three cycles.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int FIXED_PRIO   = 0,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC0  = 3'd1,
    S_ACC1  = 3'd2,
    S_DONE0 = 3'd3,
    S_DONE1 = 3'd4
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [3:0]    starve_q, starve_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          busy_q, busy_d;
  logic          grant1;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    starve_d = starve_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    grant1   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.m0_req && bus.m1_req)
          grant1 = (FIXED_PRIO != 0) ? (starve_q == LIMIT) : !last_q;
        else
          grant1 = bus.m1_req;
        if (bus.m0_req || bus.m1_req)
          state_d = grant1 ? S_ACC1 : S_ACC0;
        // Count only port-0 wins that leave port 1 waiting; saturate at the limit.
        if ((FIXED_PRIO == 0) || !bus.m1_req || grant1)
          starve_d = 4'd0;
        else if (starve_q != LIMIT)
          starve_d = starve_q + 4'd1;
      end
      S_ACC0: begin
        state_d = S_DONE0;
        last_d  = 1'b0;
        if (!bus.m0_wr) rdata0_d = bus.mem_rdata;
      end
      S_ACC1: begin
        state_d = S_DONE1;
        last_d  = 1'b1;
        if (!bus.m1_wr) rdata1_d = bus.mem_rdata;
      end
      default: state_d = S_IDLE;
    endcase
    done0_d = (state_d == S_DONE0);
    done1_d = (state_d == S_DONE1);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      starve_q <= 4'd0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      starve_q <= starve_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
    end
  end

  // Memory bus is steered from the granted port only during the access cycle;
  // the write strobe is masked by reset so an aborted access never lands.
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      S_ACC0: begin
        bus.mem_rd    = !bus.m0_wr;
        bus.mem_wr    = bus.m0_wr && !reset;
        bus.mem_addr  = bus.m0_addr;
        bus.mem_wdata = bus.m0_wdata;
      end
      S_ACC1: begin
        bus.mem_rd    = !bus.m1_wr;
        bus.mem_wr    = bus.m1_wr && !reset;
        bus.mem_addr  = bus.m1_addr;
        bus.mem_wdata = bus.m1_wdata;
      end
      default: ;
    endcase
  end

  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.m0_done   = done0_q;
  assign bus.m1_done   = done1_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance with a RAM model and a
// fixed-priority instance with an address-derived read pattern.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) ba ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) bf ();

  dmem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0), .STARVE_LIMIT(4)) dut_rr (
    .clk(clk), .reset(reset), .bus(ba.slave)
  );
  dmem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1), .STARVE_LIMIT(4)) dut_fx (
    .clk(clk), .reset(reset), .bus(bf.slave)
  );

  // ---------------- memory models ----------------
  logic [DW-1:0] mem_a [0:63];
  logic          pl_en = 1'b0;
  logic [5:0]    pl_idx = '0;
  logic [DW-1:0] pl_data = '0;

  assign ba.mem_rdata = mem_a[ba.mem_addr[7:2]];
  always @(posedge clk) begin
    if (ba.mem_wr) mem_a[ba.mem_addr[7:2]] <= ba.mem_wdata;
    else if (pl_en) mem_a[pl_idx] <= pl_data;
  end
  assign bf.mem_rdata = bf.mem_addr ^ 32'hA5A5_0000;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW:0]   exp_q[$];
  logic [DW:0]   exp_f_q[$];
  int            done_cyc_q[$];
  int            f1_cyc_q[$];
  int            done_cnt = 0;
  int            done_f_cnt = 0;
  int            wr_cycles = 0;
  logic [DW-1:0] model [0:63];
  logic [DW-1:0] exp_rd0 = '0;
  logic [DW-1:0] exp_rd1 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [DW:0] e;
    if (ba.mem_wr) wr_cycles++;
    if (ba.m0_done || ba.m1_done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
      chk("done_onehot", 32'(ba.m0_done & ba.m1_done), 0);
      if (exp_q.size() == 0) chk("spurious_done", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("done_port", 32'(ba.m1_done), 32'(e[DW]));
        if (ba.m1_done) chk("m1_rdata", ba.m1_rdata, e[DW-1:0]);
        else            chk("m0_rdata", ba.m0_rdata, e[DW-1:0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [DW:0] e;
    if (bf.m0_done || bf.m1_done) begin
      done_f_cnt++;
      if (bf.m1_done) f1_cyc_q.push_back(cyc);
      chk("fx_done_onehot", 32'(bf.m0_done & bf.m1_done), 0);
      if (exp_f_q.size() == 0) chk("fx_spurious_done", exp_f_q.size(), 1);
      else begin
        e = exp_f_q.pop_front();
        chk("fx_done_port", 32'(bf.m1_done), 32'(e[DW]));
        if (bf.m1_done) chk("fx_m1_rdata", bf.m1_rdata, e[DW-1:0]);
        else            chk("fx_m0_rdata", bf.m0_rdata, e[DW-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    exp_rd0 = '0;
    exp_rd1 = '0;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [DW-1:0] data);
    pl_en = 1'b1;
    pl_idx = idx;
    pl_data = data;
    tick();
    pl_en = 1'b0;
    model[idx] = data;
  endtask

  task automatic wait_cnt(input bit fx, input int target, input int budget);
    int n = 0;
    while (((fx ? done_f_cnt : done_cnt) < target) && (n < budget)) begin
      tick();
      n++;
    end
    chk("done_timeout", 32'((fx ? done_f_cnt : done_cnt) >= target), 1);
  endtask

  task automatic access(input bit port, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata);
    logic [DW-1:0] e;
    int tgt;
    if (wr) begin
      model[addr[7:2]] = wdata;
      e = port ? exp_rd1 : exp_rd0;
    end else begin
      e = model[addr[7:2]];
    end
    if (port) exp_rd1 = e;
    else      exp_rd0 = e;
    exp_q.push_back({port, e});
    if (port) begin
      ba.m1_req = 1'b1; ba.m1_wr = wr; ba.m1_addr = addr; ba.m1_wdata = wdata;
    end else begin
      ba.m0_req = 1'b1; ba.m0_wr = wr; ba.m0_addr = addr; ba.m0_wdata = wdata;
    end
    tgt = done_cnt + 1;
    wait_cnt(1'b0, tgt, 10);
    ba.m0_req = 1'b0;
    ba.m1_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0, base, c0;
    logic [DW-1:0] va, vb;
    logic [5:0] idx;
    ba.m0_req = 0; ba.m0_wr = 0; ba.m0_addr = '0; ba.m0_wdata = '0;
    ba.m1_req = 0; ba.m1_wr = 0; ba.m1_addr = '0; ba.m1_wdata = '0;
    bf.m0_req = 0; bf.m0_wr = 0; bf.m0_addr = '0; bf.m0_wdata = '0;
    bf.m1_req = 0; bf.m1_wr = 0; bf.m1_addr = '0; bf.m1_wdata = '0;

    do_reset();
    @(negedge clk);
    chk("rst_busy", 32'(ba.busy), 0);
    chk("rst_done", 32'({ba.m0_done, ba.m1_done}), 0);
    chk("rst_rdata0", ba.m0_rdata, 0);
    chk("rst_rdata1", ba.m1_rdata, 0);
    chk("rst_strobes", 32'({ba.mem_rd, ba.mem_wr}), 0);
    chk("rst_addr", ba.mem_addr, 0);
    chk("rst_state", 32'(ba.dbg_state), 0);
    chk("rst_fx_busy", 32'(bf.busy), 0);

    // Single read on port 0, cycle-accurate.
    preload(6'd4, 32'hDEAD_BEEF);
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    exp_rd0 = 32'hDEAD_BEEF;
    ba.m0_req = 1'b1; ba.m0_wr = 1'b0; ba.m0_addr = 32'h10;
    @(negedge clk);
    chk("t1_c0_busy", 32'(ba.busy), 0);
    tick(); @(negedge clk);
    chk("t1_c1_mem_rd", 32'(ba.mem_rd), 1);
    chk("t1_c1_mem_addr", ba.mem_addr, 32'h10);
    chk("t1_c1_busy", 32'(ba.busy), 1);
    tick(); @(negedge clk);
    chk("t1_c2_done", 32'(ba.m0_done), 1);
    chk("t1_c2_busy", 32'(ba.busy), 1);
    tick();
    ba.m0_req = 1'b0;
    @(negedge clk);
    chk("t1_c3_busy", 32'(ba.busy), 0);
    chk("t1_c3_rdata_hold", ba.m0_rdata, 32'hDEAD_BEEF);
    tick();

    // Write then read on port 1.
    w0 = wr_cycles;
    access(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    chk("t2_wr_cycles", wr_cycles - w0, 1);
    chk("t2_mem", mem_a[8], 32'h1234_5678);
    access(1'b1, 1'b0, 32'h20, '0);
    chk("t2_m0_rdata_kept", ba.m0_rdata, 32'hDEAD_BEEF);

    // Random sequential accesses on a small address window.
    for (int i = 16; i < 20; i++) preload(6'(i), $urandom);
    for (int i = 0; i < 10; i++) begin
      idx = 6'(16 + $urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {24'd0, idx, 2'b00}, $urandom);
    end

    // Round-robin contention from reset.
    va = $urandom; vb = $urandom;
    preload(6'd20, va);
    preload(6'd21, vb);
    do_reset();
    done_cyc_q.delete();
    base = done_cnt;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({1'b0, va});
      exp_q.push_back({1'b1, vb});
    end
    c0 = cyc;
    ba.m0_req = 1'b1; ba.m0_wr = 1'b0; ba.m0_addr = 32'h50;
    ba.m1_req = 1'b1; ba.m1_wr = 1'b0; ba.m1_addr = 32'h54;
    wait_cnt(1'b0, base + 4, 20);
    ba.m0_req = 1'b0; ba.m1_req = 1'b0;
    chk("rr_ndone", done_cyc_q.size(), 4);
    if (done_cyc_q.size() > 0) chk("rr_first_latency", done_cyc_q[0] - c0, 2);
    for (int i = 1; i < done_cyc_q.size(); i++) chk("rr_spacing", done_cyc_q[i] - done_cyc_q[i-1], 3);
    chk("rr_exp_empty", exp_q.size(), 0);
    repeat (2) tick();

    // Starvation guard on the fixed-priority instance.
    f1_cyc_q.delete();
    base = done_f_cnt;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) exp_f_q.push_back({1'b1, 32'hA5A5_0200});
      else            exp_f_q.push_back({1'b0, 32'hA5A5_0100});
    end
    bf.m0_req = 1'b1; bf.m0_wr = 1'b0; bf.m0_addr = 32'h100;
    bf.m1_req = 1'b1; bf.m1_wr = 1'b0; bf.m1_addr = 32'h200;
    wait_cnt(1'b1, base + 10, 40);
    bf.m0_req = 1'b0; bf.m1_req = 1'b0;
    chk("fx_m1_ndone", f1_cyc_q.size(), 2);
    if (f1_cyc_q.size() == 2) chk("fx_m1_period", f1_cyc_q[1] - f1_cyc_q[0], 15);
    chk("fx_exp_empty", exp_f_q.size(), 0);
    repeat (2) tick();

    // Reset asserted during the ACC0 cycle of a write.
    preload(6'd12, 32'h0);
    base = done_cnt;
    ba.m0_req = 1'b1; ba.m0_wr = 1'b1; ba.m0_addr = 32'h30; ba.m0_wdata = 32'hCAFE_F00D;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_acc_state", 32'(ba.dbg_state), 1);
    chk("rst_acc_mem_wr", 32'(ba.mem_wr), 0);
    tick();
    reset = 1'b0;
    ba.m0_req = 1'b0;
    exp_rd0 = '0; exp_rd1 = '0;
    @(negedge clk);
    chk("rst_acc_next_state", 32'(ba.dbg_state), 0);
    chk("rst_acc_next_busy", 32'(ba.busy), 0);
    chk("rst_acc_next_done", 32'({ba.m0_done, ba.m1_done}), 0);
    chk("rst_acc_next_strobes", 32'({ba.mem_rd, ba.mem_wr}), 0);
    chk("rst_acc_next_addr", ba.mem_addr, 0);
    chk("rst_acc_next_rdata0", ba.m0_rdata, 0);
    repeat (4) tick();
    chk("rst_acc_mem_kept", mem_a[12], 32'h0);
    chk("rst_acc_no_done", done_cnt - base, 0);

    // Port 1 request rising in the DONE0 cycle.
    va = $urandom; vb = $urandom;
    preload(6'd24, va);
    preload(6'd25, vb);
    exp_q.push_back({1'b0, va});
    ba.m0_req = 1'b1; ba.m0_wr = 1'b0; ba.m0_addr = 32'h60;
    tick();
    tick();
    exp_q.push_back({1'b1, vb});
    ba.m0_req = 1'b0;
    ba.m1_req = 1'b1; ba.m1_wr = 1'b0; ba.m1_addr = 32'h64;
    @(negedge clk);
    chk("dn_state_done0", 32'(ba.dbg_state), 3);
    chk("dn_m0_done", 32'(ba.m0_done), 1);
    tick(); @(negedge clk);
    chk("dn_idle_state", 32'(ba.dbg_state), 0);
    chk("dn_idle_mem_rd", 32'(ba.mem_rd), 0);
    tick(); @(negedge clk);
    chk("dn_acc1_state", 32'(ba.dbg_state), 2);
    chk("dn_acc1_mem_rd", 32'(ba.mem_rd), 1);
    chk("dn_acc1_addr", ba.mem_addr, 32'h64);
    tick(); @(negedge clk);
    chk("dn_m1_done", 32'(ba.m1_done), 1);
    tick();
    ba.m1_req = 1'b0;
    repeat (3) tick();

    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_fx_exp_empty", exp_f_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
